apple1_video_colour: RTL and testbench

//  Sits between the apple1 core's 1-bit VGA outputs and the HDMI wrapper. Expands r/g/b bits to

---
 rtl/apple1_video_colour.sv | 136 +++++++++++++
 tb/tb_apple1_video_colour.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apple1_video_colour.sv
//==============================================================================
// Module   : apple1_video_colour
// Purpose  : Expands 1-bit core VGA to COLOUR_W-bit channels via a palette,
//            with scanline dimming and a sync/den path of matching latency.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module apple1_video_colour #(
   parameter int         COLOUR_W        = 8,
   parameter int         PIPE_STAGES     = 2,
   parameter int         SCANLINE_SHIFT  = 1,
   parameter bit         SYNC_ACTIVE_LOW = 1'b1,
   parameter logic [1:0] DEFAULT_MODE    = 2'd0
) (
   input  logic                clk25,
   input  logic                rst_n,
   input  logic [1:0]          mode,
   input  logic                scanline_en,
   input  logic                r_bit,
   input  logic                g_bit,
   input  logic                b_bit,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic                den_in,
   output logic [COLOUR_W-1:0] vga_r,
   output logic [COLOUR_W-1:0] vga_g,
   output logic [COLOUR_W-1:0] vga_b,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                den_out,
   output logic                line_odd
);

   localparam logic                c_SYNC_ACT  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic                c_SYNC_IDLE = ~c_SYNC_ACT;
   localparam int                  c_PW        = 3 * COLOUR_W + 3;
   localparam logic [COLOUR_W-1:0] c_FULL      = '1;
   localparam logic [COLOUR_W-1:0] c_AMBER_G   = c_FULL - (c_FULL >> 2);
   localparam logic [c_PW-1:0]     c_PIPE_RST  = {1'b0, c_SYNC_IDLE, c_SYNC_IDLE, {(3*COLOUR_W){1'b0}}};

   logic                r_vs_prev;
   logic                r_den_prev;
   logic [1:0]          r_mode_q;
   logic                r_scan_q;
   logic                r_line_odd;
   logic                w_frame;
   logic                w_den_fall;
   logic                w_lit;
   logic [COLOUR_W-1:0] w_r;
   logic [COLOUR_W-1:0] w_g;
   logic [COLOUR_W-1:0] w_b;
   logic [c_PW-1:0]     w_stage1;
   logic [c_PW-1:0]     r_pipe [PIPE_STAGES];

   // Frame boundary is the first clock vsync is seen at its asserted level.
   assign w_frame    = (vsync_in == c_SYNC_ACT) && (r_vs_prev != c_SYNC_ACT);
   assign w_den_fall = r_den_prev & ~den_in;

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_prev  <= c_SYNC_IDLE;
         r_den_prev <= 1'b0;
         r_mode_q   <= DEFAULT_MODE;
         r_scan_q   <= 1'b0;
         r_line_odd <= 1'b0;
      end else begin
         r_vs_prev  <= vsync_in;
         r_den_prev <= den_in;
         if (w_frame) begin
            r_mode_q   <= mode;
            r_scan_q   <= scanline_en;
            r_line_odd <= 1'b0;
         end else if (w_den_fall) begin
            r_line_odd <= ~r_line_odd;
         end
      end
   end

   always_comb begin
      w_lit = r_bit | g_bit | b_bit;
      w_r   = '0;
      w_g   = '0;
      w_b   = '0;
      case (r_mode_q)
         2'd0: begin
            w_r = {COLOUR_W{r_bit}};
            w_g = {COLOUR_W{g_bit}};
            w_b = {COLOUR_W{b_bit}};
         end
         2'd1: begin
            w_g = w_lit ? c_FULL : '0;
         end
         2'd2: begin
            w_r = w_lit ? c_FULL : '0;
            w_g = w_lit ? c_AMBER_G : '0;
         end
         default: begin
            w_r = w_lit ? c_FULL : '0;
            w_g = w_lit ? c_FULL : '0;
            w_b = w_lit ? c_FULL : '0;
         end
      endcase
      if (!den_in) begin
         w_r = '0;
         w_g = '0;
         w_b = '0;
      end else if (r_scan_q && r_line_odd) begin
         w_r = w_r >> SCANLINE_SHIFT;
         w_g = w_g >> SCANLINE_SHIFT;
         w_b = w_b >> SCANLINE_SHIFT;
      end
   end

   assign w_stage1 = {den_in, vsync_in, hsync_in, w_r, w_g, w_b};

   // Stage 1 holds the computed colour; later stages only delay it.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            r_pipe[i] <= c_PIPE_RST;
         end
      end else begin
         r_pipe[0] <= w_stage1;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign {den_out, vsync_out, hsync_out, vga_r, vga_g, vga_b} = r_pipe[PIPE_STAGES-1];
   assign line_odd = r_line_odd;

endmodule

`default_nettype wire

// File: tb/tb_apple1_video_colour.sv
//==============================================================================
// Module   : tb_apple1_video_colour
// Purpose  : Directed, table-driven check of palette, latency, frame-deferred
//            mode/scanline latching, line parity and asynchronous reset.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_apple1_video_colour;

   logic       clk25 = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       scanline_en = 1'b0;
   logic       r_bit = 1'b0, g_bit = 1'b0, b_bit = 1'b0;
   logic       hsync_in = 1'b1, vsync_in = 1'b1, den_in = 1'b0;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       hsync_out, vsync_out, den_out, line_odd;

   int n_chk = 0;
   int n_err = 0;

   apple1_video_colour #(
      .COLOUR_W        (8),
      .PIPE_STAGES     (2),
      .SCANLINE_SHIFT  (1),
      .SYNC_ACTIVE_LOW (1'b1),
      .DEFAULT_MODE    (2'd0)
   ) dut (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .mode        (mode),
      .scanline_en (scanline_en),
      .r_bit       (r_bit),
      .g_bit       (g_bit),
      .b_bit       (b_bit),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .den_in      (den_in),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .den_out     (den_out),
      .line_odd    (line_odd)
   );

   always #5 clk25 = ~clk25;

   typedef struct {
      logic [1:0] mode;
      logic       scan, r, g, b, hs, vs, den;
      logic [7:0] er, eg, eb;
      logic       ehs, evs, eden, eodd;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mkv(input logic [1:0] m, input logic s, input logic r, input logic g,
                                input logic b, input logic hs, input logic vs, input logic den,
                                input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                                input logic ehs, input logic evs, input logic eden, input logic eodd);
      vec_t v;
      v.mode = m;   v.scan = s;  v.r = r;   v.g = g;     v.b = b;
      v.hs = hs;    v.vs = vs;   v.den = den;
      v.er = er;    v.eg = eg;   v.eb = eb;
      v.ehs = ehs;  v.evs = evs; v.eden = eden; v.eodd = eodd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rgb(input string nm, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
      chk({nm, "_r"}, {24'd0, vga_r}, {24'd0, er});
      chk({nm, "_g"}, {24'd0, vga_g}, {24'd0, eg});
      chk({nm, "_b"}, {24'd0, vga_b}, {24'd0, eb});
   endtask

   task automatic chk_reset_state(input string nm);
      chk_rgb(nm, 8'h00, 8'h00, 8'h00);
      chk({nm, "_hs"},  {31'd0, hsync_out}, 32'd1);
      chk({nm, "_vs"},  {31'd0, vsync_out}, 32'd1);
      chk({nm, "_den"}, {31'd0, den_out},   32'd0);
      chk({nm, "_odd"}, {31'd0, line_odd},  32'd0);
   endtask

   // Inputs are driven just after a falling edge and held for two rising
   // edges, so the outputs reflect them at the following falling edge.
   task automatic apply(input int idx);
      vec_t  v;
      string nm;
      v = tbl[idx];
      mode = v.mode; scanline_en = v.scan;
      r_bit = v.r; g_bit = v.g; b_bit = v.b;
      hsync_in = v.hs; vsync_in = v.vs; den_in = v.den;
      @(negedge clk25);
      @(negedge clk25);
      nm = $sformatf("vec%0d", idx);
      chk_rgb(nm, v.er, v.eg, v.eb);
      chk({nm, "_hs"},  {31'd0, hsync_out}, {31'd0, v.ehs});
      chk({nm, "_vs"},  {31'd0, vsync_out}, {31'd0, v.evs});
      chk({nm, "_den"}, {31'd0, den_out},   {31'd0, v.eden});
      chk({nm, "_odd"}, {31'd0, line_odd},  {31'd0, v.eodd});
   endtask

   initial begin
      //              mode s  r  g  b  hs vs de   R      G      B     hs vs de odd
      tbl[0]  = mkv(2'd0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
      tbl[1]  = mkv(2'd0, 0, 1, 0, 0, 1, 1, 1, 8'hFF, 8'h00, 8'h00, 1, 1, 1, 0);
      tbl[2]  = mkv(2'd0, 0, 0, 1, 1, 1, 1, 1, 8'h00, 8'hFF, 8'hFF, 1, 1, 1, 0);
      tbl[3]  = mkv(2'd0, 0, 1, 1, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
      tbl[4]  = mkv(2'd0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1);
      tbl[5]  = mkv(2'd2, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
      tbl[6]  = mkv(2'd2, 0, 0, 1, 0, 1, 1, 1, 8'hFF, 8'hC0, 8'h00, 1, 1, 1, 0);
      tbl[7]  = mkv(2'd2, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
      tbl[8]  = mkv(2'd1, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
      tbl[9]  = mkv(2'd1, 0, 1, 0, 0, 1, 1, 1, 8'h00, 8'hFF, 8'h00, 1, 1, 1, 0);
      tbl[10] = mkv(2'd3, 0, 1, 0, 0, 1, 1, 1, 8'h00, 8'hFF, 8'h00, 1, 1, 1, 0);
      tbl[11] = mkv(2'd3, 0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
      tbl[12] = mkv(2'd3, 0, 0, 0, 1, 1, 1, 1, 8'h00, 8'hFF, 8'h00, 1, 1, 1, 1);
      tbl[13] = mkv(2'd3, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
      tbl[14] = mkv(2'd3, 1, 1, 0, 0, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0);
      tbl[15] = mkv(2'd3, 1, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
      tbl[16] = mkv(2'd3, 1, 0, 1, 0, 1, 1, 1, 8'h7F, 8'h7F, 8'h7F, 1, 1, 1, 1);
      tbl[17] = mkv(2'd3, 1, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
      tbl[18] = mkv(2'd3, 1, 0, 0, 1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0);
      tbl[19] = mkv(2'd3, 1, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
      tbl[20] = mkv(2'd3, 1, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1);

      // Reset state, during and after reset with idle inputs
      repeat (3) @(negedge clk25);
      chk_reset_state("in_reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk25);
      chk_reset_state("idle");

      // Latency: single-clock red pulse appears exactly two clocks later
      den_in = 1'b1;
      repeat (3) @(negedge clk25);
      r_bit = 1'b1;
      @(negedge clk25);
      r_bit = 1'b0;
      chk("lat_t1_r", {24'd0, vga_r}, 32'h00);
      @(negedge clk25);
      chk_rgb("lat_t2", 8'hFF, 8'h00, 8'h00);
      @(negedge clk25);
      chk("lat_t3_r", {24'd0, vga_r}, 32'h00);

      // Fresh reset before the table so it starts from known parity
      den_in = 1'b0;
      @(negedge clk25);
      rst_n = 1'b0;
      @(negedge clk25);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) apply(i);

      // den fall coinciding with vsync edge: frame boundary clears parity
      den_in = 1'b0;
      repeat (2) @(negedge clk25);
      chk("simul_pre_odd", {31'd0, line_odd}, 32'd0);
      den_in = 1'b1;
      @(negedge clk25);
      den_in = 1'b0;
      vsync_in = 1'b0;
      @(negedge clk25);
      chk("simul_odd", {31'd0, line_odd}, 32'd0);

      // White pixel mid-line, then asynchronous reset between clock edges
      vsync_in = 1'b1;
      den_in = 1'b1;
      r_bit = 1'b1;
      repeat (3) @(negedge clk25);
      chk_rgb("preres", 8'hFF, 8'hFF, 8'hFF);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("async_rst");
      @(negedge clk25);
      rst_n = 1'b1;

      // First frame after reset uses the default RGB mode despite mode=3
      repeat (3) @(negedge clk25);
      chk_rgb("postres", 8'hFF, 8'h00, 8'h00);
      vsync_in = 1'b0;
      @(negedge clk25);
      vsync_in = 1'b1;
      repeat (3) @(negedge clk25);
      chk_rgb("postres_frame", 8'hFF, 8'hFF, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
